// File: rtl/mod_reduce_serial.sv
// mod_reduce_serial
// -----------------------------------------------------------------------------
// Limb-serial modular correction unit. A single LIMB-bit adder is iterated over
// NL = WIDTH/LIMB limbs to perform either
//   op=0 : reduce     result = C mod P          (C < 2P, C is WIDTH+1 bits)
//   op=1 : modsub     result = (A - B) mod P    (A, B < P)
// The subtract pass computes X - S limb by limb (S = P or B). For op=1 a
// borrow triggers a second pass that adds P back.
//
// Ports
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   start   : request, accepted when start=1 and busy=0
//   op      : 0 = reduce, 1 = modular subtraction
//   in_a    : WIDTH+1 bits, operand C (op=0) or A (op=1)
//   in_b    : WIDTH bits, subtrahend B (op=1 only)
//   in_p    : WIDTH bits, modulus P
//   busy    : high from the cycle after acceptance until the done cycle
//   done    : one-cycle completion pulse
//   result  : last computed result, updated only in the done cycle
// -----------------------------------------------------------------------------
module mod_reduce_serial #(
    parameter int WIDTH = 1040,
    parameter int LIMB  = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH:0]   in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_p,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int NL   = WIDTH / LIMB;
    localparam int IDXW = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NL - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                      state_r;
    logic                        op_r;
    logic                        xt_r;      // bit WIDTH of the latched C/A
    logic [NL-1:0][LIMB-1:0]     x_r;       // low WIDTH bits of the latched C/A
    logic [NL-1:0][LIMB-1:0]     s_r;       // subtrahend: P (op=0) or B (op=1)
    logic [NL-1:0][LIMB-1:0]     p_r;       // modulus for the add-back pass
    logic [NL-1:0][LIMB-1:0]     d_r;       // working difference / sum
    logic [IDXW-1:0]             idx_r;
    logic                        carry_r;

    logic                        top_s;
    logic [LIMB:0]               add_a_s;
    logic [LIMB:0]               add_b_s;
    logic [LIMB+1:0]             sum_s;
    logic [NL-1:0][LIMB-1:0]     d_new_s;

    // Shared limb adder: operand selection per pass plus the updated D vector.
    always_comb begin
        top_s   = (idx_r == LAST_IDX);
        add_a_s = '0;
        add_b_s = '0;
        case (state_r)
            ST_SUB: begin
                // The top limb carries the extra C bit; the inverted subtrahend
                // is sign-extended with a 1 so bit LIMB+1 becomes the no-borrow flag.
                add_a_s = {top_s & xt_r, x_r[idx_r]};
                add_b_s = {top_s, ~s_r[idx_r]};
            end
            ST_FIX: begin
                add_a_s = {1'b0, d_r[idx_r]};
                add_b_s = {1'b0, p_r[idx_r]};
            end
            default: begin
                add_a_s = '0;
                add_b_s = '0;
            end
        endcase
        sum_s          = {1'b0, add_a_s} + {1'b0, add_b_s} + {{(LIMB+1){1'b0}}, carry_r};
        d_new_s        = d_r;
        d_new_s[idx_r] = sum_s[LIMB-1:0];
    end

    // Control FSM with registered handshake outputs and the limb datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_r    <= 1'b0;
            xt_r    <= 1'b0;
            x_r     <= '0;
            s_r     <= '0;
            p_r     <= '0;
            d_r     <= '0;
            idx_r   <= '0;
            carry_r <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r    <= op;
                        xt_r    <= in_a[WIDTH];
                        x_r     <= in_a[WIDTH-1:0];
                        s_r     <= op ? in_b : in_p;
                        p_r     <= in_p;
                        carry_r <= 1'b1;   // +1 completes the two's-complement of S
                        idx_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_SUB;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SUB: begin
                    d_r <= d_new_s;
                    if (!top_s) begin
                        carry_r <= sum_s[LIMB];
                        idx_r   <= idx_r + IDX_ONE;
                    end else if (!op_r) begin
                        // Reduce: keep C when C < P, otherwise C - P.
                        result  <= sum_s[LIMB+1] ? d_new_s : x_r;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_DONE;
                    end else if (sum_s[LIMB+1]) begin
                        result  <= d_new_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        // A < B: the difference wrapped, add P back.
                        carry_r <= 1'b0;
                        idx_r   <= '0;
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    d_r <= d_new_s;
                    if (!top_s) begin
                        carry_r <= sum_s[LIMB];
                        idx_r   <= idx_r + IDX_ONE;
                    end else begin
                        // Final carry-out is dropped: the sum is taken mod 2^WIDTH.
                        result  <= d_new_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mod_reduce_serial.md
Name: mod_reduce_serial

Overview:
- Parametrised, limb-serial modular correction unit for the wide modular-multiplier datapath.
- Generalises the fixed 1040-bit conditional subtract-P stage:
  - WIDTH and LIMB are parameters.
  - It adds a start/busy/done handshake with latched operands.
  - It adds a second mode, modular subtraction (A-B mod P), with a P add-back pass.
- It uses one LIMB-bit adder, iterated over limbs, so area stays small at full operand width.

Parameters:
- WIDTH, 1040, modulus width in bits; must be a multiple of LIMB.
- LIMB, 65, adder width per cycle; NL = WIDTH/LIMB limbs.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted when start=1 and busy=0
- op  input  1  0 = reduce (in_a mod P, in_a < 2P); 1 = modsub ((in_a - in_b) mod P)
- in_a  input  WIDTH+1  operand C (op=0) or A (op=1; in_a[WIDTH] must be 0, A < P)
- in_b  input  WIDTH  subtrahend B (op=1 only, B < P); ignored for op=0
- in_p  input  WIDTH  modulus P, nonzero
- busy  output  1  high from the cycle after acceptance until the done cycle (exclusive)
- done  output  1  one-cycle pulse; result is valid from this cycle on
- result  output  WIDTH  last computed result, held until the next done

Behaviour:
- Reset (rst_n low, async): state=IDLE, busy=0, done=0, result=0, limb counter=0, carry=0, internal registers cleared. Reset mid-operation aborts the operation; no done is produced.
- Acceptance latches in_a, in_b, in_p, op; later input changes have no effect until the next acceptance.
- FSM states: IDLE, SUB, FIX, DONE.
- IDLE:
  - On start, latch operands, carry<=1 (two's-complement subtract), idx<=0, go to SUB.
  - Subtrahend S = P when op=0, B when op=1.
- SUB, one limb per cycle, idx 0..NL-1:
  - {c, D[idx]} = X[idx] + ~S[idx] + carry, where X is the latched A.
  - Top limb also includes X[WIDTH]: the top-limb sum is (LIMB+1)-bit X slice + {1'b1, ~S slice} + carry; its MSB carry-out is the final no-borrow flag nb.
  - After the last limb:
    - op=0: result <= nb ? D : X[WIDTH-1:0]; go to DONE.
    - op=1, nb=1: result <= D; go to DONE.
    - op=1, nb=0 (A<B): carry<=0, idx<=0, go to FIX.
- FIX, NL cycles: D[idx] <= D[idx] + P[idx] + carry; the carry-out of the last limb is discarded (mod 2^WIDTH). Then result<=D; go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; the next state is IDLE. A start asserted in the DONE cycle is accepted, giving back-to-back operation.
- start while busy=1 is ignored; no queueing.
- Latency, acceptance edge to done cycle:
  - NL+1 cycles for op=0, and for op=1 without borrow.
  - 2*NL+1 cycles for op=1 with borrow.
- Output boundaries:
  - op=0, C=P gives 0.
  - op=0, C=0 gives 0.
  - op=0, C=2P-1 gives P-1.
  - op=1, A=B gives 0.
- Inputs violating the preconditions produce an undefined result value, but the handshake timing must remain correct.
- result changes only in the done cycle. busy and done are registered outputs; there are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=8, LIMB=4 (NL=2), P=13; reset then op=0, C=20 → done 3 cycles after acceptance, result=7; C=12 → 12; C=13 → 0; C=25 → 12.
- Same config, op=1, A=5, B=9 → borrow path, done at 5 cycles, result=9; A=9, B=5 → done at 3 cycles, result=4; A=B=7 → 0.
- Handshake:
  - Pulse start with busy=1 → ignored; result and done timing of the in-flight op are unchanged.
  - Start in the done cycle → accepted, second done arrives NL+1 cycles later.
  - Inputs changed after acceptance → no effect.
- Reset mid-SUB and mid-FIX (rst_n low asynchronously, between edges) → busy, done and result are 0 immediately; no spurious done after release.
- Default WIDTH=1040, LIMB=65:
  - P = 2^1039+1, C = 2P-1 → result = P-1 = 2^1039, done at 17 cycles.
  - op=1, A=0, B=1 → result = P-1, done at 33 cycles.
- Random regression (≥10k ops, both modes, both configs) against a reference model → all results match; the latency rule holds every time.
